// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state
// encodings and the bit-counter width helper.
package serial_arith_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Width of a counter that walks bit positions 0 .. width-1.
   // Clamped to one bit so a degenerate width still gives a legal vector.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = x - y - bin, with the borrow out of this bit.
module full_subtractor_bit
   import serial_arith_pkg::*;
(
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference bit and borrow generation for a single bit position
   always_comb begin
      d    = x ^ y ^ bin;
      bout = (~x & y) | (~x & bin) | (y & bin);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes X - Y - BIN one bit per clock, LSB first.
// Operands are captured on accept; D/BOUT are held until the next completion.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 4
)
(
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic             BIN,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] D,
   output logic             BOUT
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   logic [0:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] xs;
   logic [WIDTH-1:0] ys;
   logic [WIDTH-1:0] rs;
   logic             b;
   logic [WIDTH-1:0] d_r;
   logic             bout_r;
   logic             done_r;

   logic             dbit;
   logic             bnext;
   logic [WIDTH-1:0] rs_next;
   logic             last;

   // The single bit slice always works on the current LSBs and borrow flop
   full_subtractor_bit u_bit (
      .x    (xs[0]),
      .y    (ys[0]),
      .bin  (b),
      .d    (dbit),
      .bout (bnext)
   );

   assign rs_next = {dbit, rs[WIDTH-1:1]};
   assign last    = (state == ST_RUN) && (cnt == LAST_BIT);

   // FSM, bit counter, operand shift registers and borrow flop
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_IDLE;
         cnt   <= '0;
         xs    <= '0;
         ys    <= '0;
         rs    <= '0;
         b     <= 1'b0;
      end else if (state == ST_IDLE) begin
         if (START) begin
            xs    <= X;
            ys    <= Y;
            b     <= BIN;
            cnt   <= '0;
            state <= ST_RUN;
         end
      end else begin
         xs <= xs >> 1;
         ys <= ys >> 1;
         rs <= rs_next;
         b  <= bnext;
         if (cnt == LAST_BIT) begin
            cnt   <= '0;
            state <= ST_IDLE;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // Result registers load only on the edge that finishes the last bit
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         d_r    <= '0;
         bout_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= last;
         if (last) begin
            d_r    <= rs_next;
            bout_r <= bnext;
         end
      end
   end

   assign BUSY = (state == ST_RUN);
   assign DONE = done_r;
   assign D    = d_r;
   assign BOUT = bout_r;

endmodule
